// File: rtl/fill_master_pkg.sv
// Shared types and helpers for the Avalon-MM fill master.
// Word-size helpers keep the byte/word relationship in one place.
package fill_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        FINISH = 2'd2
    } fill_state_t;

    localparam int DEFAULT_DATA_W = 32;
    localparam int BYTES_PER_WORD = DEFAULT_DATA_W / 8;
    localparam int ADDR_LSB       = $clog2(BYTES_PER_WORD);

    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/avalon_fill_master.sv
// Avalon-MM write-only master that fills a contiguous word region with a pattern.
// Define FILL_MASTER_INCREMENT_EN to turn the pattern into a +1 ramp per accepted word.
module avalon_fill_master
    import fill_master_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_address,
    input  logic [CNT_W-1:0]  word_count,
    input  logic [DATA_W-1:0] fill_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] writedata,
    output logic              write,
    input  logic              waitrequest
);

    localparam int BPW = bytes_per_word(DATA_W);
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(BPW);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(BPW - 1));

    fill_state_t       state, state_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] data_n;
    logic [CNT_W-1:0]  rem, rem_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            address   <= '0;
            writedata <= '0;
            rem       <= '0;
        end else begin
            state     <= state_n;
            address   <= addr_n;
            writedata <= data_n;
            rem       <= rem_n;
        end
    end

    always_comb begin
        state_n = state;
        addr_n  = address;
        data_n  = writedata;
        rem_n   = rem;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (word_count != '0) begin
                        state_n = WRITE;
                        addr_n  = base_address & ALIGN_MASK;
                        data_n  = fill_data;
                        rem_n   = word_count;
                    end else begin
                        state_n = FINISH;
                    end
                end
            end
            WRITE: begin
                // bus signals hold while the slave stalls
                if (!waitrequest) begin
                    rem_n = rem - CNT_W'(1);
`ifdef FILL_MASTER_INCREMENT_EN
                    data_n = writedata + DATA_W'(1);
`endif
                    if (rem == CNT_W'(1)) begin
                        state_n = FINISH;
                    end else begin
                        addr_n = address + STEP;
                    end
                end
            end
            FINISH: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // decoded from state so reset clears them without waiting for a clock
    assign write = (state == WRITE);
    assign busy  = (state == WRITE);
    assign done  = (state == FINISH);

endmodule

// File: tb/tb_avalon_fill_master.sv
// Self-checking bench for avalon_fill_master with a word-list reference model.
// Honours FILL_MASTER_INCREMENT_EN when predicting write data.
module tb_avalon_fill_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] base_address;
    logic [15:0] word_count;
    logic [31:0] fill_data;
    logic        busy;
    logic        done;
    logic [31:0] address;
    logic [31:0] writedata;
    logic        write;
    logic        waitrequest;

    avalon_fill_master #(
        .ADDR_W(32),
        .DATA_W(32),
        .CNT_W (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .base_address(base_address),
        .word_count  (word_count),
        .fill_data   (fill_data),
        .busy        (busy),
        .done        (done),
        .address     (address),
        .writedata   (writedata),
        .write       (write),
        .waitrequest (waitrequest)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    int done_at;
    int stall_cycles;
    int hold_err;
    int busy_err;
    bit wr_seen;
    bit busy_seen;
    logic busy_at_done;
    logic done_after;
    logic write_after;

    function automatic logic [31:0] exp_addr(input logic [31:0] base, input int i);
        return (base & 32'hFFFF_FFFC) + 32'(i) * 32'd4;
    endfunction

    function automatic logic [31:0] exp_data(input logic [31:0] seed, input int i);
`ifdef FILL_MASTER_INCREMENT_EN
        return seed + 32'(i);
`else
        if (i < 0) return 32'h0;
        return seed;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one fill and records every accepted word; returns at posedge+1.
    task automatic run_fill(input logic [31:0] base, input logic [15:0] cnt,
                            input logic [31:0] data, input int mode,
                            input int stall_word, input bit inject);
        bit held;
        bit s;
        logic [31:0] ha;
        logic [31:0] hd;
        int c;
        int sw;
        int limit;
        obs_addr.delete();
        obs_data.delete();
        done_at = -1;
        stall_cycles = 0;
        hold_err = 0;
        busy_err = 0;
        wr_seen = 0;
        busy_seen = 0;
        busy_at_done = 1'bx;
        held = 0;
        sw = 0;
        limit = 3 * int'(cnt) + 40;
        base_address = base;
        word_count = cnt;
        fill_data = data;
        waitrequest = 1'b0;
        start = 1'b1;
        step();
        c = 1;
        while (c <= limit) begin
            base_address = $urandom;
            word_count = 16'($urandom);
            fill_data = $urandom;
            start = inject ? 1'($urandom_range(0, 1)) : 1'b0;
            if (write === 1'b1) wr_seen = 1;
            if (busy === 1'b1) busy_seen = 1;
            if (done === 1'b1) begin
                done_at = c;
                busy_at_done = busy;
                break;
            end
            if (busy !== 1'b1 || write !== 1'b1) busy_err++;
            if (held && (address !== ha || writedata !== hd)) hold_err++;
            case (mode)
                1: s = (obs_addr.size() == stall_word) && (sw < 2);
                2: s = ($urandom_range(0, 3) == 0);
                default: s = 0;
            endcase
            waitrequest = s;
            if (write === 1'b1) begin
                if (s) begin
                    stall_cycles++;
                    sw++;
                    held = 1;
                    ha = address;
                    hd = writedata;
                end else begin
                    held = 0;
                    obs_addr.push_back(address);
                    obs_data.push_back(writedata);
                end
            end
            step();
            c++;
        end
        start = 1'b0;
        waitrequest = 1'b0;
        step();
        done_after = done;
        write_after = write;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        base_address = '0;
        word_count = '0;
        fill_data = '0;
        waitrequest = 1'b0;
        step();
        step();
        checks++; if (write !== 1'b0) begin errors++; $display("FAIL reset_write: got %b expected 0", write); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (address !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", address); end
        checks++; if (writedata !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", writedata); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        run_fill(32'h100, 16'd4, 32'hDEADBEEF, 0, 0, 0);
        checks++; if (obs_addr.size() != 4) begin errors++; $display("FAIL basic_count: got %0d expected 4", obs_addr.size()); end
        for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
            checks++; if (obs_addr[i] !== 32'h100 + 32'(4 * i)) begin errors++; $display("FAIL basic_addr[%0d]: got %h expected %h", i, obs_addr[i], 32'h100 + 32'(4 * i)); end
            checks++; if (obs_data[i] !== exp_data(32'hDEADBEEF, i)) begin errors++; $display("FAIL basic_data[%0d]: got %h expected %h", i, obs_data[i], exp_data(32'hDEADBEEF, i)); end
        end
        checks++; if (done_at != 5) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 5", done_at); end
        checks++; if (busy_err != 0) begin errors++; $display("FAIL basic_busy: got %0d bad cycles expected 0", busy_err); end
        checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b expected 0", busy_at_done); end
        checks++; if (done_after !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b expected 0", done_after); end
    endtask

    task automatic test_stall();
        run_fill(32'h0000_4000, 16'd3, 32'hCAFE0001, 1, 1, 0);
        checks++; if (obs_addr.size() != 3) begin errors++; $display("FAIL stall_count: got %0d expected 3", obs_addr.size()); end
        for (int i = 0; i < obs_addr.size() && i < 3; i++) begin
            checks++; if (obs_addr[i] !== exp_addr(32'h4000, i)) begin errors++; $display("FAIL stall_addr[%0d]: got %h expected %h", i, obs_addr[i], exp_addr(32'h4000, i)); end
            checks++; if (obs_data[i] !== exp_data(32'hCAFE0001, i)) begin errors++; $display("FAIL stall_data[%0d]: got %h expected %h", i, obs_data[i], exp_data(32'hCAFE0001, i)); end
        end
        checks++; if (stall_cycles != 2) begin errors++; $display("FAIL stall_cycles: got %0d expected 2", stall_cycles); end
        checks++; if (hold_err != 0) begin errors++; $display("FAIL stall_hold: got %0d unstable cycles expected 0", hold_err); end
        checks++; if (done_at != 6) begin errors++; $display("FAIL stall_done_cycle: got %0d expected 6", done_at); end
        checks++; if (done_after !== 1'b0) begin errors++; $display("FAIL stall_done_width: got %b expected 0", done_after); end
    endtask

    task automatic test_zero();
        run_fill(32'h40, 16'd0, 32'h11111111, 0, 0, 0);
        checks++; if (wr_seen) begin errors++; $display("FAIL zero_write: got 1 expected 0"); end
        checks++; if (busy_seen) begin errors++; $display("FAIL zero_busy: got 1 expected 0"); end
        checks++; if (done_at != 1) begin errors++; $display("FAIL zero_done_cycle: got %0d expected 1", done_at); end
        checks++; if (done_after !== 1'b0) begin errors++; $display("FAIL zero_done_width: got %b expected 0", done_after); end
    endtask

    task automatic test_busy_start();
        run_fill(32'h1000, 16'd6, 32'h12345678, 0, 0, 1);
        checks++; if (obs_addr.size() != 6) begin errors++; $display("FAIL busy_start_count: got %0d expected 6", obs_addr.size()); end
        for (int i = 0; i < obs_addr.size() && i < 6; i++) begin
            checks++; if (obs_addr[i] !== exp_addr(32'h1000, i)) begin errors++; $display("FAIL busy_start_addr[%0d]: got %h expected %h", i, obs_addr[i], exp_addr(32'h1000, i)); end
            checks++; if (obs_data[i] !== exp_data(32'h12345678, i)) begin errors++; $display("FAIL busy_start_data[%0d]: got %h expected %h", i, obs_data[i], exp_data(32'h12345678, i)); end
        end
        checks++; if (done_at != 7) begin errors++; $display("FAIL busy_start_done_cycle: got %0d expected 7", done_at); end
        checks++; if (write_after !== 1'b0) begin errors++; $display("FAIL busy_start_requeue: got write=%b expected 0", write_after); end
    endtask

    task automatic test_reset_mid();
        int bad;
        bad = 0;
        base_address = 32'h3000;
        word_count = 16'd8;
        fill_data = 32'hAAAA5555;
        waitrequest = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        checks++; if (address !== 32'h3008) begin errors++; $display("FAIL rmid_pre_addr: got %h expected 00003008", address); end
        #2 reset = 1'b1;
        #1;
        checks++; if (write !== 1'b0) begin errors++; $display("FAIL rmid_write: got %b expected 0", write); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", busy); end
        checks++; if (address !== 32'h0) begin errors++; $display("FAIL rmid_addr: got %h expected 0", address); end
        checks++; if (writedata !== 32'h0) begin errors++; $display("FAIL rmid_data: got %h expected 0", writedata); end
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done !== 1'b0 || write !== 1'b0) bad++;
            step();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rmid_no_done: got %0d active cycles expected 0", bad); end
        run_fill(32'h3000, 16'd2, 32'h0BADF00D, 0, 0, 0);
        checks++; if (obs_addr.size() != 2) begin errors++; $display("FAIL rmid_restart_count: got %0d expected 2", obs_addr.size()); end
        for (int i = 0; i < obs_addr.size() && i < 2; i++) begin
            checks++; if (obs_addr[i] !== exp_addr(32'h3000, i)) begin errors++; $display("FAIL rmid_restart_addr[%0d]: got %h expected %h", i, obs_addr[i], exp_addr(32'h3000, i)); end
        end
        checks++; if (done_at != 3) begin errors++; $display("FAIL rmid_restart_done: got %0d expected 3", done_at); end
    endtask

    task automatic test_unaligned();
        logic [31:0] ea [3];
        logic [31:0] ed [3];
        ea[0] = 32'h200; ea[1] = 32'h204; ea[2] = 32'h208;
`ifdef FILL_MASTER_INCREMENT_EN
        ed[0] = 32'hFFFFFFFE; ed[1] = 32'hFFFFFFFF; ed[2] = 32'h00000000;
`else
        ed[0] = 32'hFFFFFFFE; ed[1] = 32'hFFFFFFFE; ed[2] = 32'hFFFFFFFE;
`endif
        run_fill(32'h203, 16'd3, 32'hFFFFFFFE, 0, 0, 0);
        checks++; if (obs_addr.size() != 3) begin errors++; $display("FAIL unaligned_count: got %0d expected 3", obs_addr.size()); end
        for (int i = 0; i < obs_addr.size() && i < 3; i++) begin
            checks++; if (obs_addr[i] !== ea[i]) begin errors++; $display("FAIL unaligned_addr[%0d]: got %h expected %h", i, obs_addr[i], ea[i]); end
            checks++; if (obs_data[i] !== ed[i]) begin errors++; $display("FAIL unaligned_data[%0d]: got %h expected %h", i, obs_data[i], ed[i]); end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] ea [4];
        ea[0] = 32'hFFFFFFF8; ea[1] = 32'hFFFFFFFC; ea[2] = 32'h0; ea[3] = 32'h4;
        run_fill(32'hFFFFFFF9, 16'd4, 32'h5A5A5A5A, 0, 0, 0);
        checks++; if (obs_addr.size() != 4) begin errors++; $display("FAIL wrap_count: got %0d expected 4", obs_addr.size()); end
        for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
            checks++; if (obs_addr[i] !== ea[i]) begin errors++; $display("FAIL wrap_addr[%0d]: got %h expected %h", i, obs_addr[i], ea[i]); end
        end
        checks++; if (done_at != 5) begin errors++; $display("FAIL wrap_done_cycle: got %0d expected 5", done_at); end
    endtask

    task automatic test_random();
        logic [31:0] b;
        logic [31:0] d;
        logic [15:0] n;
        int bad;
        for (int it = 0; it < 10; it++) begin
            b = $urandom;
            d = $urandom;
            n = 16'($urandom_range(0, 12));
            bad = 0;
            run_fill(b, n, d, 2, 0, 1'($urandom_range(0, 1)));
            checks++; if (obs_addr.size() != int'(n)) begin errors++; $display("FAIL rand%0d_count: got %0d expected %0d", it, obs_addr.size(), n); end
            for (int i = 0; i < obs_addr.size() && i < int'(n); i++) begin
                if (obs_addr[i] !== exp_addr(b, i) || obs_data[i] !== exp_data(d, i)) bad++;
            end
            checks++; if (bad != 0) begin errors++; $display("FAIL rand%0d_words: got %0d wrong words expected 0", it, bad); end
            checks++; if (done_at != int'(n) + 1 + stall_cycles) begin errors++; $display("FAIL rand%0d_done_cycle: got %0d expected %0d", it, done_at, int'(n) + 1 + stall_cycles); end
            checks++; if (hold_err != 0 || busy_err != 0) begin errors++; $display("FAIL rand%0d_hold: got %0d/%0d bad cycles expected 0", it, hold_err, busy_err); end
            checks++; if (done_after !== 1'b0 || write_after !== 1'b0) begin errors++; $display("FAIL rand%0d_after: got done=%b write=%b expected 0", it, done_after, write_after); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_zero();
        test_busy_start();
        test_reset_mid();
        test_unaligned();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
